cansec_tx_secure: RTL and testbench
===================================

# cansec_tx_secure

Transmit-side CANsec securing stage, the counterpart of the receive-side security checker. For each outgoing CAN XL frame marked secure, it allocates the next freshness value (FV), has the external ICV engine compute the 128-bit ICV, and hands FV+ICV to the TX frame builder. It commits the FV counter only on confirmed transmission, so retransmissions reuse the same FV. It sits between the TX request logic and the TX frame builder, alongside the shared AES/CMAC engine.

## Interface
- FV_W, 32, freshness value width
- ICV_W, 128, ICV width
- ICV_TIMEOUT, 1024, max cycles from ICV request to icv_done

- clk  in  1  system clock, rising edge
- g_rst_n  in  1  global reset, synchronous, active-low
- sec_en  in  1  frame is CANsec-secured; sampled with tx_req_valid
- tx_req_valid  in  1  new frame to prepare
- tx_req_ready  out  1  block accepts request
- icv_req  out  1  start ICV computation; held until icv_ack
- icv_ack  in  1  engine accepted request
- icv_fv  out  FV_W  FV the engine must include in the MAC input
- icv_done  in  1  one-cycle pulse, ICV valid
- icv_dataout  in  ICV_W  computed ICV
- sec_out_valid  out  1  fv/icv valid for frame builder
- sec_out_ready  in  1  frame builder accepts
- fv  out  FV_W  FV to insert in frame
- icv  out  ICV_W  ICV to append
- tx_success  in  1  frame transmitted and acknowledged
- tx_abort  in  1  transmission lost or errored; frame will be retried
- security_err  out  1  FV exhausted or ICV timeout
- fv_cnt  out  FV_W  last committed FV

## Operation
- States: IDLE, ICV_REQ, ICV_WAIT, HANDOFF, WAIT_RESULT, ERR.
- IDLE: tx_req_ready=1. On accept:
  - sec_en=1 and fv_cnt≠all-ones: fv_next=fv_cnt+1, go to ICV_REQ; security_err cleared.
  - sec_en=1 and fv_cnt=all-ones: FV exhausted; go to ERR, no wrap to 0 (the receiver treats 0 as the unsynchronised value).
  - sec_en=0: fv=0, icv=0, go to HANDOFF (bypass, no FV consumed).
- ICV_REQ: icv_req=1, icv_fv=fv_next. On icv_ack go to ICV_WAIT.
- ICV_WAIT: on icv_done capture icv_dataout into icv, go to HANDOFF. If icv_ack and icv_done coincide in ICV_REQ, capture and go directly to HANDOFF.
- HANDOFF: sec_out_valid=1, fv/icv stable. On sec_out_ready go to WAIT_RESULT.
- WAIT_RESULT:
  - tx_success: fv_cnt<=fv (secured frames only), go to IDLE.
  - tx_abort: go to HANDOFF with the same fv/icv (retry, no new ICV).
  - Both in the same cycle: tx_success wins.
- ERR: security_err<=1 for one cycle in ERR, then IDLE. security_err is sticky until the next accepted request or reset.
- Timeout: a counter runs in ICV_REQ and ICV_WAIT and resets on entry to ICV_REQ. When it reaches ICV_TIMEOUT, go to ERR, drop icv_req, and leave fv_cnt unchanged.
- fv_cnt changes only on tx_success; comparison and increment are unsigned FV_W.

## Timing
- Reset (g_rst_n=0 at clk edge): state IDLE; fv_cnt=0, fv=0, icv=0, icv_fv=0, icv_req=0, sec_out_valid=0, security_err=0, tx_req_ready=0 during reset and 1 the cycle after.
- Reset mid-operation aborts everything; in-flight FV is not committed and icv_req drops immediately.
- Accept at edge N; icv_req high from N+1. Zero-wait engine (ack at N+1, done at N+2) gives sec_out_valid at N+3.
- Bypass latency: accept at N, sec_out_valid at N+1.
- tx_success/tx_abort are ignored outside WAIT_RESULT.
- All outputs are registered.

## Structure
- Package cansec_pkg: FV_W/ICV_W defaults, state enum, FV_EXHAUSTED constant (all-ones), shared with the RX security checker.
- One sub-module, cansec_fv_counter: holds fv_cnt, provides fv_next and an exhausted flag, with a commit input; reusable by the RX side for old_fv tracking.

## Test plan
- Secured frame, zero-wait engine: fv_cnt=5 → icv_fv=6, icv=0xA5..A5 and fv=6 at N+3; tx_success → fv_cnt=6.
- tx_abort twice, then tx_success: fv=6 and the same icv re-presented each time; icv_req pulses once; final fv_cnt=6.
- Engine never asserts icv_done, ICV_TIMEOUT=16: security_err=1 about 17 cycles after accept; fv_cnt unchanged; next request clears security_err.
- fv_cnt forced to 0xFFFFFFFF, secured request: no icv_req, security_err=1, fv_cnt stays 0xFFFFFFFF.
- sec_en=0: sec_out_valid at N+1 with fv=0, icv=0; tx_success leaves fv_cnt unchanged.
- g_rst_n low during ICV_WAIT: next cycle icv_req=0, IDLE, all outputs at reset values; tx_success and tx_abort in the same cycle → commit.

Source files
------------

// File: rtl/cansec_pkg.sv
// Shared CANsec definitions for the TX securing stage and the RX security checker.
package cansec_pkg;

    localparam int DEF_FV_W        = 32;
    localparam int DEF_ICV_W       = 128;
    localparam int DEF_ICV_TIMEOUT = 1024;

    // Highest usable FV; the counter must never wrap because 0 means "unsynchronised".
    localparam logic [DEF_FV_W-1:0] FV_EXHAUSTED = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ICV_REQ,
        ST_ICV_WAIT,
        ST_HANDOFF,
        ST_WAIT_RESULT,
        ST_ERR
    } cansec_state_e;

endpackage

// File: rtl/cansec_fv_counter.sv
// Freshness value counter: holds the last committed FV, offers the next FV and an exhausted flag.
// Updates only on commit; also usable on the RX side to track the last accepted FV.
module cansec_fv_counter
    import cansec_pkg::*;
#(
    parameter int              FV_W    = DEF_FV_W,
    parameter logic [FV_W-1:0] FV_INIT = '0
) (
    input  logic            clk,
    input  logic            g_rst_n,
    input  logic            commit_i,
    input  logic [FV_W-1:0] commit_fv_i,
    output logic [FV_W-1:0] fv_cnt_o,
    output logic [FV_W-1:0] fv_next_o,
    output logic            exhausted_o
);

    logic [FV_W-1:0] cnt_q;
    logic [FV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (commit_i) begin
            cnt_d = commit_fv_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!g_rst_n) begin
            cnt_q <= FV_INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fv_cnt_o    = cnt_q;
    assign fv_next_o   = cnt_q + FV_W'(1);
    assign exhausted_o = (cnt_q == {FV_W{1'b1}});

endmodule

// File: rtl/cansec_tx_secure.sv
// CANsec TX securing stage: allocates the next FV, obtains the ICV from the shared engine and hands
// FV+ICV to the frame builder; the FV counter commits only on confirmed transmission.
module cansec_tx_secure
    import cansec_pkg::*;
#(
    parameter int              FV_W        = DEF_FV_W,
    parameter int              ICV_W       = DEF_ICV_W,
    parameter int              ICV_TIMEOUT = DEF_ICV_TIMEOUT,
    parameter logic [FV_W-1:0] FV_INIT     = '0
) (
    input  logic             clk,
    input  logic             g_rst_n,
    input  logic             sec_en,
    input  logic             tx_req_valid,
    output logic             tx_req_ready,
    output logic             icv_req,
    input  logic             icv_ack,
    output logic [FV_W-1:0]  icv_fv,
    input  logic             icv_done,
    input  logic [ICV_W-1:0] icv_dataout,
    output logic             sec_out_valid,
    input  logic             sec_out_ready,
    output logic [FV_W-1:0]  fv,
    output logic [ICV_W-1:0] icv,
    input  logic             tx_success,
    input  logic             tx_abort,
    output logic             security_err,
    output logic [FV_W-1:0]  fv_cnt
);

    localparam int TMO_W = $clog2(ICV_TIMEOUT + 1);

    cansec_state_e    state_q, state_d;
    logic             tx_req_ready_q;
    logic             icv_req_q;
    logic             sec_out_valid_q;
    logic             security_err_q;
    logic             sec_q;
    logic [FV_W-1:0]  fv_q;
    logic [FV_W-1:0]  icv_fv_q;
    logic [ICV_W-1:0] icv_q;
    logic [TMO_W-1:0] tmo_q;

    logic             accept;
    logic             tmo_expired;
    logic             icv_capture;
    logic             commit;
    logic [FV_W-1:0]  fv_next;
    logic             fv_exhausted;

    assign accept      = (state_q == ST_IDLE) && tx_req_ready_q && tx_req_valid;
    assign tmo_expired = (tmo_q >= TMO_W'(ICV_TIMEOUT - 1));
    assign icv_capture = icv_done &&
                         (((state_q == ST_ICV_REQ) && icv_ack) || (state_q == ST_ICV_WAIT));
    // Bypass frames never consumed an FV, so they must not move the counter.
    assign commit      = (state_q == ST_WAIT_RESULT) && tx_success && sec_q;

    cansec_fv_counter #(
        .FV_W    (FV_W),
        .FV_INIT (FV_INIT)
    ) u_fv_counter (
        .clk         (clk),
        .g_rst_n     (g_rst_n),
        .commit_i    (commit),
        .commit_fv_i (fv_q),
        .fv_cnt_o    (fv_cnt),
        .fv_next_o   (fv_next),
        .exhausted_o (fv_exhausted)
    );

    always_ff @(posedge clk) begin
        if (!g_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!sec_en)           state_d = ST_HANDOFF;
                    else if (fv_exhausted) state_d = ST_ERR;
                    else                   state_d = ST_ICV_REQ;
                end
            end
            ST_ICV_REQ: begin
                if (icv_ack && icv_done) state_d = ST_HANDOFF;
                else if (icv_ack)        state_d = ST_ICV_WAIT;
                else if (tmo_expired)    state_d = ST_ERR;
            end
            ST_ICV_WAIT: begin
                if (icv_done)         state_d = ST_HANDOFF;
                else if (tmo_expired) state_d = ST_ERR;
            end
            ST_HANDOFF: begin
                if (sec_out_ready) state_d = ST_WAIT_RESULT;
            end
            ST_WAIT_RESULT: begin
                if (tx_success)    state_d = ST_IDLE;
                else if (tx_abort) state_d = ST_HANDOFF;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!g_rst_n) begin
            tx_req_ready_q  <= 1'b0;
            icv_req_q       <= 1'b0;
            sec_out_valid_q <= 1'b0;
            security_err_q  <= 1'b0;
            sec_q           <= 1'b0;
            fv_q            <= '0;
            icv_fv_q        <= '0;
            icv_q           <= '0;
            tmo_q           <= '0;
        end else begin
            tx_req_ready_q  <= (state_d == ST_IDLE);
            icv_req_q       <= (state_d == ST_ICV_REQ);
            sec_out_valid_q <= (state_d == ST_HANDOFF);

            if (accept) begin
                sec_q <= sec_en;
                tmo_q <= '0;
                if (!sec_en) begin
                    fv_q  <= '0;
                    icv_q <= '0;
                end else if (!fv_exhausted) begin
                    fv_q     <= fv_next;
                    icv_fv_q <= fv_next;
                end
            end else if (((state_q == ST_ICV_REQ) || (state_q == ST_ICV_WAIT)) && !tmo_expired) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            if (icv_capture) begin
                icv_q <= icv_dataout;
            end

            if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
                security_err_q <= 1'b1;
            end else if (accept) begin
                security_err_q <= 1'b0;
            end
        end
    end

    assign tx_req_ready  = tx_req_ready_q;
    assign icv_req       = icv_req_q;
    assign icv_fv        = icv_fv_q;
    assign sec_out_valid = sec_out_valid_q;
    assign fv            = fv_q;
    assign icv           = icv_q;
    assign security_err  = security_err_q;

endmodule

// File: tb/tb_cansec_tx_secure.sv
// Directed bench for cansec_tx_secure: secured/bypass flows, retry, ICV timeout, FV exhaustion, reset.
module tb_cansec_tx_secure;
    import cansec_pkg::*;

    logic         clk = 1'b0;
    logic         g_rst_n;
    logic         sec_en;
    logic         tx_req_valid;
    logic         tx_req_valid2;
    logic         icv_ack;
    logic         icv_done;
    logic [127:0] icv_dataout;
    logic         sec_out_ready;
    logic         tx_success;
    logic         tx_abort;

    logic         tx_req_ready, icv_req, sec_out_valid, security_err;
    logic [31:0]  icv_fv, fv, fv_cnt;
    logic [127:0] icv;

    logic         tx_req_ready2, icv_req2, sec_out_valid2, security_err2;
    logic [31:0]  icv_fv2, fv2, fv_cnt2;
    logic [127:0] icv2;

    int n_tests = 0;
    int n_fail  = 0;
    int req_pulses = 0;
    logic prev_req = 1'b0;

    localparam logic [127:0] ICV_A5 = {16{8'hA5}};
    localparam logic [127:0] ICV_3C = {16{8'h3C}};

    cansec_tx_secure #(.FV_W(32), .ICV_W(128), .ICV_TIMEOUT(16)) dut (
        .clk(clk), .g_rst_n(g_rst_n), .sec_en(sec_en),
        .tx_req_valid(tx_req_valid), .tx_req_ready(tx_req_ready),
        .icv_req(icv_req), .icv_ack(icv_ack), .icv_fv(icv_fv),
        .icv_done(icv_done), .icv_dataout(icv_dataout),
        .sec_out_valid(sec_out_valid), .sec_out_ready(sec_out_ready),
        .fv(fv), .icv(icv), .tx_success(tx_success), .tx_abort(tx_abort),
        .security_err(security_err), .fv_cnt(fv_cnt)
    );

    // Second instance whose counter starts at the exhausted value.
    cansec_tx_secure #(.FV_W(32), .ICV_W(128), .ICV_TIMEOUT(16), .FV_INIT(FV_EXHAUSTED)) dut_ex (
        .clk(clk), .g_rst_n(g_rst_n), .sec_en(sec_en),
        .tx_req_valid(tx_req_valid2), .tx_req_ready(tx_req_ready2),
        .icv_req(icv_req2), .icv_ack(icv_ack), .icv_fv(icv_fv2),
        .icv_done(icv_done), .icv_dataout(icv_dataout),
        .sec_out_valid(sec_out_valid2), .sec_out_ready(sec_out_ready),
        .fv(fv2), .icv(icv2), .tx_success(tx_success), .tx_abort(tx_abort),
        .security_err(security_err2), .fv_cnt(fv_cnt2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (icv_req && !prev_req) req_pulses++;
        prev_req = icv_req;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input string tag, input logic se);
        int k = 0;
        while (!tx_req_ready && k < 50) begin
            tick();
            k++;
        end
        chk(tag, tx_req_ready, 1'b1);
        sec_en       = se;
        tx_req_valid = 1'b1;
        tick();
        tx_req_valid = 1'b0;
        sec_en       = 1'b0;
    endtask

    task automatic engine_zero(input logic [127:0] v);
        icv_ack = 1'b1;
        tick();
        icv_ack     = 1'b0;
        icv_done    = 1'b1;
        icv_dataout = v;
        tick();
        icv_done = 1'b0;
    endtask

    task automatic handoff();
        sec_out_ready = 1'b1;
        tick();
        sec_out_ready = 1'b0;
    endtask

    task automatic result(input logic s, input logic a);
        tx_success = s;
        tx_abort   = a;
        tick();
        tx_success = 1'b0;
        tx_abort   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int pulses0;
        g_rst_n = 1'b0; sec_en = 1'b0; tx_req_valid = 1'b0; tx_req_valid2 = 1'b0;
        icv_ack = 1'b0; icv_done = 1'b0; icv_dataout = '0; sec_out_ready = 1'b0;
        tx_success = 1'b0; tx_abort = 1'b0;
        repeat (3) tick();

        chk("rst_ready", tx_req_ready, 1'b0);
        chk("rst_icv_req", icv_req, 1'b0);
        chk("rst_valid", sec_out_valid, 1'b0);
        chk("rst_err", security_err, 1'b0);
        chk("rst_fv_cnt", fv_cnt, 32'd0);
        chk("rst_fv", fv, 32'd0);
        chk("rst_icv", icv, 128'd0);
        chk("rst_icv_fv", icv_fv, 32'd0);
        chk("rst_ex_fv_cnt", fv_cnt2, 32'hFFFF_FFFF);
        chk("rst_ex_misc", {sec_out_valid2, fv2, icv_fv2, icv2}, '0);
        g_rst_n = 1'b1;
        tick();
        chk("rst_ready_after", tx_req_ready, 1'b1);

        // Commit five frames to bring fv_cnt to 5.
        for (int i = 1; i <= 5; i++) begin
            accept("warm_rdy", 1'b1);
            chk("warm_icv_fv", icv_fv, 32'(i));
            engine_zero({4{32'(i)}});
            chk("warm_fv", fv, 32'(i));
            handoff();
            result(1'b1, 1'b0);
            chk("warm_fv_cnt", fv_cnt, 32'(i));
        end

        // Zero-wait engine: accept at N, valid visible after N+2.
        pulses0 = req_pulses;
        accept("sec_rdy", 1'b1);
        chk("sec_icv_req", icv_req, 1'b1);
        chk("sec_icv_fv", icv_fv, 32'd6);
        icv_ack = 1'b1;
        tick();
        icv_ack = 1'b0; icv_done = 1'b1; icv_dataout = ICV_A5;
        chk("sec_valid_early", sec_out_valid, 1'b0);
        tick();
        icv_done = 1'b0; icv_dataout = '0;
        chk("sec_valid", sec_out_valid, 1'b1);
        chk("sec_fv", fv, 32'd6);
        chk("sec_icv", icv, ICV_A5);
        chk("sec_req_drop", icv_req, 1'b0);

        // Two aborts re-present the same FV/ICV without a new ICV request.
        for (int r = 0; r < 2; r++) begin
            handoff();
            result(1'b0, 1'b1);
            chk("retry_valid", sec_out_valid, 1'b1);
            chk("retry_fv", fv, 32'd6);
            chk("retry_icv", icv, ICV_A5);
        end
        result(1'b1, 1'b0);
        chk("ignore_success_valid", sec_out_valid, 1'b1);
        chk("ignore_success_cnt", fv_cnt, 32'd5);
        handoff();
        result(1'b1, 1'b0);
        chk("retry_commit", fv_cnt, 32'd6);
        chk("retry_req_pulses", req_pulses - pulses0, 1);

        // ICV timeout: engine acks but never completes.
        accept("tmo_rdy", 1'b1);
        chk("tmo_icv_fv", icv_fv, 32'd7);
        icv_ack = 1'b1;
        tick();
        icv_ack = 1'b0;
        k = 1;
        while (!security_err && k < 40) begin
            tick();
            k++;
        end
        chk("tmo_latency", k, 16);
        chk("tmo_req_drop", icv_req, 1'b0);
        chk("tmo_fv_cnt", fv_cnt, 32'd6);
        tick();
        chk("tmo_err_sticky", security_err, 1'b1);
        chk("tmo_idle", tx_req_ready, 1'b1);

        // Bypass: clears the sticky error, valid one edge after accept, no FV consumed.
        accept("byp_rdy", 1'b0);
        chk("byp_err_clr", security_err, 1'b0);
        chk("byp_valid", sec_out_valid, 1'b1);
        chk("byp_fv", fv, 32'd0);
        chk("byp_icv", icv, 128'd0);
        chk("byp_no_req", icv_req, 1'b0);
        handoff();
        result(1'b1, 1'b0);
        chk("byp_fv_cnt", fv_cnt, 32'd6);

        // FV exhausted on the second instance.
        sec_en = 1'b1; tx_req_valid2 = 1'b1;
        chk("ex_rdy", tx_req_ready2, 1'b1);
        tick();
        tx_req_valid2 = 1'b0; sec_en = 1'b0;
        chk("ex_err", security_err2, 1'b1);
        chk("ex_no_req", icv_req2, 1'b0);
        tick();
        chk("ex_no_req2", icv_req2, 1'b0);
        chk("ex_fv_cnt", fv_cnt2, 32'hFFFF_FFFF);
        chk("ex_idle", tx_req_ready2, 1'b1);

        // Reset during ICV_WAIT discards the in-flight FV.
        accept("rmid_rdy", 1'b1);
        chk("rmid_icv_fv", icv_fv, 32'd7);
        icv_ack = 1'b1;
        tick();
        icv_ack = 1'b0;
        g_rst_n = 1'b0;
        tick();
        chk("rmid_req", icv_req, 1'b0);
        chk("rmid_ready", tx_req_ready, 1'b0);
        chk("rmid_fv_cnt", fv_cnt, 32'd0);
        chk("rmid_outs", {sec_out_valid, security_err, fv, icv_fv, icv}, '0);
        g_rst_n = 1'b1;
        tick();
        chk("rmid_ready_after", tx_req_ready, 1'b1);

        // Ack and done together, then success and abort together: success wins.
        accept("both_rdy", 1'b1);
        chk("both_icv_fv", icv_fv, 32'd1);
        icv_ack = 1'b1; icv_done = 1'b1; icv_dataout = ICV_3C;
        tick();
        icv_ack = 1'b0; icv_done = 1'b0; icv_dataout = '0;
        chk("both_valid", sec_out_valid, 1'b1);
        chk("both_icv", icv, ICV_3C);
        handoff();
        result(1'b1, 1'b1);
        chk("both_commit", fv_cnt, 32'd1);
        chk("both_idle", tx_req_ready, 1'b1);
        chk("both_valid_low", sec_out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
